// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b, LSB first) with a start/busy/done handshake.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sd;
    logic [WIDTH-1:0] sd_next;
    logic             br;
    logic             br_next;
    logic             bit_d;
    logic             last_bit;
    logic [CW-1:0]    cnt;

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             a_msb;
    logic             b_msb;
`endif

    // Full-subtractor cell on the current LSBs; the borrow flop carries between cycles.
    assign bit_d    = sa[0] ^ sb[0] ^ br;
    assign br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    assign sd_next  = {bit_d, sd[WIDTH-1:1]};
    assign last_bit = (cnt == LAST);

    // NOTE: sequential state uses <= so every flop samples pre-edge values; blocking here would chain them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: diff/borrow only move on the completing edge, so partial results never leak out.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        br  <= 1'b0;
                        cnt <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sd  <= sd_next;
                    br  <= br_next;
                    cnt <= cnt + 1'b1;
                    if (last_bit) begin
                        diff   <= sd_next;
                        borrow <= br_next;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        // The final serial bit is the result sign bit.
                        ovf    <= (a_msb ^ b_msb) & (a_msb ^ bit_d);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed, random, abort and back-to-back scenarios
// against an arithmetic reference model. Define SERIAL_SUB_OVERFLOW_EN to also cover ovf.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic.
    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        int r;
        r = (int'(x) - int'(y) + (1 << W)) % (1 << W);
        return W'(r);
    endfunction

    function automatic logic ref_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
        return int'(x) < int'(y);
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
        int r;
        r = int'($signed(x)) - int'($signed(y));
        return (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    endfunction

    // Drives one accepted start and waits for done; returns what was observed.
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         output logic [W-1:0] got_diff, output logic got_borrow,
                         output logic got_ovf, output int busy_cycles,
                         output int done_cycle);
        @(negedge clk);
        a     = xa;
        b     = xb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        busy_cycles = 0;
        done_cycle  = -1;
        got_diff    = 'x;
        got_borrow  = 1'bx;
        got_ovf     = 1'bx;
        for (int i = 1; i <= 4 * W; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                done_cycle = i;
                got_diff   = diff;
                got_borrow = borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
                got_ovf    = ovf;
`else
                got_ovf    = 1'b0;
`endif
                break;
            end
        end
    endtask

    task automatic check_op(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb);
        logic [W-1:0] d;
        logic         br;
        logic         o;
        int           bc;
        int           dc;
        do_op(xa, xb, d, br, o, bc, dc);
        checks++;
        if (dc !== W + 1) begin
            errors++;
            $display("FAIL %s done_cycle got %0d expected %0d", name, dc, W + 1);
        end
        checks++;
        if (bc !== W) begin
            errors++;
            $display("FAIL %s busy_cycles got %0d expected %0d", name, bc, W);
        end
        checks++;
        if (d !== ref_diff(xa, xb) || br !== ref_borrow(xa, xb)) begin
            errors++;
            $display("FAIL %s a=%h b=%h diff/borrow got %h/%b expected %h/%b",
                     name, xa, xb, d, br, ref_diff(xa, xb), ref_borrow(xa, xb));
        end
`ifdef SERIAL_SUB_OVERFLOW_EN
        checks++;
        if (o !== ref_ovf(xa, xb)) begin
            errors++;
            $display("FAIL %s a=%h b=%h ovf got %b expected %b", name, xa, xb, o, ref_ovf(xa, xb));
        end
`endif
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_width got %b expected 0", name, done);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, diff, borrow} !== '0) begin
            errors++;
            $display("FAIL reset busy/done/diff/borrow got %b/%b/%h/%b expected 0/0/00/0",
                     busy, done, diff, borrow);
        end
`ifdef SERIAL_SUB_OVERFLOW_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf got %b expected 0", ovf);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_directed();
        check_op("dir_5_3", 8'd5, 8'd3);
        check_op("dir_3_5", 8'd3, 8'd5);
        check_op("dir_00_ff", 8'h00, 8'hFF);
        check_op("dir_a5_a5", 8'hA5, 8'hA5);
        check_op("dir_00_01", 8'h00, 8'h01);
        check_op("dir_ff_00", 8'hFF, 8'h00);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            check_op("random", W'($urandom), W'($urandom));
        end
    endtask

    // A start during RUN must be dropped without disturbing the running operation.
    task automatic test_ignored_start();
        int nb;
        int pulses;
        logic [W-1:0] first_diff;
        nb = 0;
        pulses = 0;
        first_diff = 'x;
        @(negedge clk);
        a = 8'd200;
        b = 8'd57;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 3 * W; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin
                pulses++;
                if (pulses == 1) first_diff = diff;
            end
            if (nb == 3 && busy) begin
                a = 8'd1;
                b = 8'd2;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL ignored_start done_pulses got %0d expected 1", pulses);
        end
        checks++;
        if (first_diff !== 8'd143) begin
            errors++;
            $display("FAIL ignored_start diff got %h expected %h", first_diff, 8'd143);
        end
    endtask

    task automatic test_reset_abort();
        int nb;
        int pulses;
        check_op("pre_abort", 8'd9, 8'd2);
        @(negedge clk);
        a = 8'd50;
        b = 8'd20;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        nb = 0;
        for (int i = 0; i < 2 * W && nb < 4; i++) begin
            @(negedge clk);
            if (busy) nb++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, diff, borrow} !== '0) begin
            errors++;
            $display("FAIL abort_reset busy/done/diff/borrow got %b/%b/%h/%b expected 0/0/00/0",
                     busy, done, diff, borrow);
        end
        pulses = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL abort_no_done busy/done cycles got %0d expected 0", pulses);
        end
        check_op("post_abort", 8'd50, 8'd20);
    endtask

    // With start held high, results repeat every W+2 cycles and diff never glitches in between.
    task automatic test_back_to_back();
        int pulses;
        int last;
        int bad_gap;
        int bad_val;
        pulses = 0;
        last = -1;
        bad_gap = 0;
        bad_val = 0;
        @(negedge clk);
        a = 8'd10;
        b = 8'd4;
        start = 1'b1;
        for (int i = 1; i <= 3 * (W + 2) + 2; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (last >= 0 && i - last != W + 2) bad_gap++;
                last = i;
            end
            if (last >= 0 && diff !== 8'd6) bad_val++;
        end
        start = 1'b0;
        repeat (W + 3) @(negedge clk);
        checks++;
        if (pulses !== 3) begin
            errors++;
            $display("FAIL b2b_pulses got %0d expected 3", pulses);
        end
        checks++;
        if (bad_gap !== 0) begin
            errors++;
            $display("FAIL b2b_spacing bad_gaps got %0d expected 0", bad_gap);
        end
        checks++;
        if (bad_val !== 0) begin
            errors++;
            $display("FAIL b2b_diff_stable bad_cycles got %0d expected 0", bad_val);
        end
    endtask

`ifdef SERIAL_SUB_OVERFLOW_EN
    task automatic test_overflow();
        check_op("ovf_80_01", 8'h80, 8'h01);
        check_op("ovf_7f_ff", 8'h7F, 8'hFF);
        check_op("ovf_5_3", 8'd5, 8'd3);
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignored_start();
        test_reset_abort();
        test_back_to_back();
`ifdef SERIAL_SUB_OVERFLOW_EN
        test_overflow();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
